imem_sync_loadable: RTL and testbench

- Parametrised next-generation instruction memory for the pipelined core.
- Registered (1-cycle) fetch port with stall/flush control, address fault detection, a runtime program-loader port, and optional clear-on-reset sweep.
- Sits between the IF-stage PC register and the IF/ID pipeline register; the loader is driven by the testbench or a debug/boot master.

---
 rtl/imem_sync_loadable.sv | 200 ++++++++++++++++++++
 tb/tb_imem_sync_loadable.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync_loadable.sv
// Instruction memory with a registered fetch port and a runtime program loader.
//
// Sits between the IF-stage PC and the IF/ID register. Fetches return one cycle
// after the request and honour flush and stall. A loader port fills the memory
// while the block is in LOAD. An optional sweep writes NOP_WORD everywhere after reset.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   fetch_req     fetch request, address on fetch_addr
//   stall, flush  hold / kill the fetch outputs
//   fetch_valid   fetch_data / fetch_pc / fetch_fault are meaningful
//   fetch_data    fetched word (NOP_WORD on bubbles and faults)
//   fetch_pc      address of the fetched word
//   fetch_fault   fetched address misaligned or out of range
//   ld_start      enter LOAD
//   ld_we         loader write strobe (ld_addr / ld_data)
//   ld_done       leave LOAD
//   ld_err        sticky: a loader write was dropped for a bad address
//   busy          high while in LOAD or CLEAR
module imem_sync_loadable #(
  parameter int unsigned        DATA_W       = 32,
  parameter int unsigned        DEPTH        = 1024,
  parameter bit                 BYTE_ADDR    = 1'b1,
  parameter logic [DATA_W-1:0]  NOP_WORD     = 'h00000013,
  parameter bit                 CLEAR_ON_RST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic [31:0]       fetch_pc,
  output logic              fetch_fault,
  input  logic              ld_start,
  input  logic              ld_we,
  input  logic [31:0]       ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              ld_err,
  output logic              busy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned Lsb  = BYTE_ADDR ? 2 : 0;
  localparam int unsigned Hi   = IdxW + Lsb;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [1:0] {StRun, StLoad, StClear} state_e;

  // Any set bit above the index field, or a non-word-aligned byte address.
  function automatic logic addr_fault(input logic [31:0] a);
    logic misaligned;
    logic out_of_range;
    misaligned   = BYTE_ADDR && (a[1:0] != 2'b00);
    out_of_range = ((a >> Hi) != 32'd0);
    return misaligned || out_of_range;
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [31:0] a);
    logic [31:0] s;
    s = a >> Lsb;
    return s[IdxW-1:0];
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [IdxW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              from_mem_q, from_mem_d;
  logic              ld_err_q, ld_err_d;
  logic              busy_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              rd_en;
  logic              mem_we;
  logic [IdxW-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              fetch_flt;
  logic              ld_flt;
  logic [IdxW-1:0]   fetch_idx;
  logic [IdxW-1:0]   ld_idx;

  assign fetch_flt = addr_fault(fetch_addr);
  assign ld_flt    = addr_fault(ld_addr);
  assign fetch_idx = addr_idx(fetch_addr);
  assign ld_idx    = addr_idx(ld_addr);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    from_mem_d = from_mem_q;
    ld_err_d   = ld_err_q;
    rd_en      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ld_idx;
    mem_wdata  = ld_data;

    unique case (state_q)
      StRun: begin
        if (ld_start || flush) begin
          // ld_start wins over everything; both produce a bubble.
          if (ld_start) state_d = StLoad;
          valid_d    = 1'b0;
          fault_d    = 1'b0;
          from_mem_d = 1'b0;
        end else if (stall) begin
          // hold all fetch outputs
        end else if (fetch_req) begin
          valid_d    = 1'b1;
          pc_d       = fetch_addr;
          fault_d    = fetch_flt;
          from_mem_d = !fetch_flt;
          rd_en      = !fetch_flt;
        end else begin
          valid_d    = 1'b0;
          fault_d    = 1'b0;
          from_mem_d = 1'b0;
        end
      end

      StLoad: begin
        valid_d    = 1'b0;
        fault_d    = 1'b0;
        from_mem_d = 1'b0;
        if (ld_we) begin
          if (ld_flt) ld_err_d = 1'b1;
          else        mem_we   = 1'b1;
        end
        if (ld_done) state_d = StRun;
      end

      StClear: begin
        valid_d    = 1'b0;
        fault_d    = 1'b0;
        from_mem_d = 1'b0;
        mem_we     = 1'b1;
        mem_waddr  = cnt_q;
        mem_wdata  = NOP_WORD;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IdxW'(1);
        end
      end

      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RST ? StClear : StRun;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      pc_q       <= 32'd0;
      fault_q    <= 1'b0;
      from_mem_q <= 1'b0;
      ld_err_q   <= 1'b0;
      busy_q     <= CLEAR_ON_RST;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      from_mem_q <= from_mem_d;
      ld_err_q   <= ld_err_d;
      busy_q     <= (state_d != StRun);
    end
  end

  // Storage has no reset; only the CLEAR sweep touches every word.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Read register only updates on an accepted fetch, so a stall holds it.
  always_ff @(posedge clk) begin
    if (rd_en && !rst) rd_data_q <= mem[fetch_idx];
  end

  assign fetch_valid = valid_q;
  assign fetch_data  = from_mem_q ? rd_data_q : NOP_WORD;
  assign fetch_pc    = pc_q;
  assign fetch_fault = fault_q;
  assign ld_err      = ld_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_imem_sync_loadable.sv
module tb_imem_sync_loadable;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: DEPTH=1024, byte addressing, no clear sweep.
  logic        rst, fetch_req, stall, flush, ld_start, ld_we, ld_done;
  logic [31:0] fetch_addr, ld_addr, ld_data;
  logic        fetch_valid, fetch_fault, ld_err, busy;
  logic [31:0] fetch_data, fetch_pc;

  // Sweep instance: DEPTH=16, CLEAR_ON_RST=1.
  logic        c_rst, c_fetch_req;
  logic [31:0] c_fetch_addr;
  logic        c_fetch_valid, c_fetch_fault, c_ld_err, c_busy;
  logic [31:0] c_fetch_data, c_fetch_pc;
  logic        c_zero;
  logic [31:0] c_zero32;

  int checks = 0;
  int failures = 0;

  imem_sync_loadable u_dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_pc    (fetch_pc),
    .fetch_fault (fetch_fault),
    .ld_start    (ld_start),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_done     (ld_done),
    .ld_err      (ld_err),
    .busy        (busy)
  );

  imem_sync_loadable #(
    .DEPTH        (16),
    .CLEAR_ON_RST (1'b1)
  ) u_clr (
    .clk         (clk),
    .rst         (c_rst),
    .fetch_req   (c_fetch_req),
    .fetch_addr  (c_fetch_addr),
    .stall       (c_zero),
    .flush       (c_zero),
    .fetch_valid (c_fetch_valid),
    .fetch_data  (c_fetch_data),
    .fetch_pc    (c_fetch_pc),
    .fetch_fault (c_fetch_fault),
    .ld_start    (c_zero),
    .ld_we       (c_zero),
    .ld_addr     (c_zero32),
    .ld_data     (c_zero32),
    .ld_done     (c_zero),
    .ld_err      (c_ld_err),
    .busy        (c_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                           input logic exp_fault);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    check_eq({tag, "_valid"}, 64'(fetch_valid), 64'(1'b1));
    check_eq({tag, "_data"},  64'(fetch_data),  64'(exp_data));
    check_eq({tag, "_pc"},    64'(fetch_pc),    64'(a));
    check_eq({tag, "_fault"}, 64'(fetch_fault), 64'(exp_fault));
  endtask

  logic [31:0] prog [4];
  int          n;

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00100113;
    prog[2] = 32'h002081b3;
    prog[3] = 32'h00000013;

    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
    ld_start = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    c_rst = 1'b1; c_fetch_req = 1'b0; c_fetch_addr = '0; c_zero = 1'b0; c_zero32 = '0;

    tick(); tick();
    rst = 1'b0;
    check_eq("rst_valid", 64'(fetch_valid), 64'(0));
    check_eq("rst_data",  64'(fetch_data),  64'h13);
    check_eq("rst_pc",    64'(fetch_pc),    64'(0));
    check_eq("rst_fault", 64'(fetch_fault), 64'(0));
    check_eq("rst_lderr", 64'(ld_err),      64'(0));
    check_eq("rst_busy",  64'(busy),        64'(0));

    // Preload; the last write shares its cycle with ld_done.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check_eq("load_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) begin
      ld_we   = 1'b1;
      ld_addr = 32'(i * 4);
      ld_data = prog[i];
      ld_done = (i == 3);
      fetch_req = 1'b1; fetch_addr = 32'h0;  // ignored in LOAD
      tick();
      check_eq("load_valid", 64'(fetch_valid), 64'(0));
    end
    ld_we = 1'b0; ld_done = 1'b0;
    check_eq("load_exit_busy", 64'(busy), 64'(0));

    fetch_chk("f0", 32'h0, 32'h00500093, 1'b0);
    fetch_chk("f4", 32'h4, 32'h00100113, 1'b0);
    fetch_chk("f8", 32'h8, 32'h002081b3, 1'b0);
    fetch_chk("fc", 32'hc, 32'h00000013, 1'b0);

    // Stall holds the previous fetch.
    fetch_chk("s4", 32'h4, 32'h00100113, 1'b0);
    stall = 1'b1; fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_data",  64'(fetch_data),  64'h00100113);
      check_eq("stall_pc",    64'(fetch_pc),    64'h4);
      check_eq("stall_valid", 64'(fetch_valid), 64'(1));
    end
    stall = 1'b0;
    tick();
    check_eq("unstall_data", 64'(fetch_data), 64'h002081b3);
    check_eq("unstall_pc",   64'(fetch_pc),   64'h8);

    // Flush beats stall and fetch_req.
    flush = 1'b1; stall = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h8;
    tick();
    flush = 1'b0; stall = 1'b0;
    check_eq("flush_valid", 64'(fetch_valid), 64'(0));
    check_eq("flush_data",  64'(fetch_data),  64'h13);

    // Faults.
    fetch_chk("mis", 32'h2,    32'h13, 1'b1);
    fetch_chk("oor", 32'h1000, 32'h13, 1'b1);
    fetch_chk("ok4", 32'h4,    32'h00100113, 1'b0);
    fetch_req = 1'b0;
    tick();
    check_eq("idle_valid", 64'(fetch_valid), 64'(0));
    check_eq("idle_data",  64'(fetch_data),  64'h13);

    // ld_start during a fetch stream, then overwrite word 0 and try an aliasing bad write.
    fetch_req = 1'b1; fetch_addr = 32'h0; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check_eq("ldst_valid", 64'(fetch_valid), 64'(0));
    check_eq("ldst_busy",  64'(busy),        64'(1));
    ld_we = 1'b1; ld_addr = 32'h0; ld_data = 32'hdeadbeef;
    tick();
    ld_addr = 32'h1000; ld_data = 32'h0badf00d;
    tick();
    ld_we = 1'b0;
    check_eq("lderr_set",  64'(ld_err),      64'(1));
    check_eq("ld_valid",   64'(fetch_valid), 64'(0));
    check_eq("ld_busy",    64'(busy),        64'(1));
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check_eq("ld_exit_busy", 64'(busy), 64'(0));
    fetch_chk("coh", 32'h0, 32'hdeadbeef, 1'b0);
    check_eq("lderr_sticky", 64'(ld_err), 64'(1));

    // ld_start together with ld_done in RUN: done is ignored.
    fetch_req = 1'b0; ld_start = 1'b1; ld_done = 1'b1;
    tick();
    ld_start = 1'b0; ld_done = 1'b0;
    check_eq("stdone_busy", 64'(busy), 64'(1));
    tick();
    check_eq("stdone_busy2", 64'(busy), 64'(1));
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    check_eq("stdone_exit", 64'(busy), 64'(0));

    // Reset clears ld_err but not memory.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_lderr", 64'(ld_err), 64'(0));
    fetch_chk("keep", 32'h8, 32'h002081b3, 1'b0);
    fetch_req = 1'b0;

    // Clear sweep.
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    check_eq("clr_busy0", 64'(c_busy), 64'(1));
    n = 0;
    while (c_busy && n < 100) begin
      tick();
      n++;
    end
    check_eq("clr_cycles", 64'(n), 64'(16));
    for (int i = 0; i < 16; i++) begin
      c_fetch_req = 1'b1; c_fetch_addr = 32'(i * 4);
      tick();
      check_eq("clr_word", 64'(c_fetch_data), 64'h13);
      check_eq("clr_wvalid", 64'(c_fetch_valid), 64'(1));
    end
    c_fetch_req = 1'b0;

    // Reset in the middle of a sweep restarts it.
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    n = 0;
    while (c_busy && n < 100) begin
      tick();
      n++;
    end
    check_eq("clr_restart", 64'(n), 64'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
